instruction_sequencer: RTL and testbench

- Multi-cycle control FSM that drives the 16-bit datapath block.
- Owns the program counter (PC) and the instruction register (IR). Fetches from block RAM, decodes opcode classes and drives every datapath select and enable line, one state per cycle.
- Sits between the top level (run/boot controls) and the datapath. The datapath's ALU control decodes the ALU operation from IR; this block does not generate ALU opcodes.

---
 rtl/instruction_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Multi-cycle fetch/decode/execute controller; owns PC and IR
//               and drives the 16-bit datapath select and enable lines.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HALT_OPEXT = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        bootLoad,
  input  logic [15:0] bootPc,
  input  logic [15:0] ramReadData,
  input  logic [15:0] aluOutput,
  output logic [15:0] instruction,
  output logic [15:0] programCounter,
  output logic        blockRamReadEnable,
  output logic        blockRamWriteEnable,
  output logic        registerFileWriteEnable,
  output logic [1:0]  integerTypeSelectionLine,
  output logic        reg2OrImmediateSelectionLine,
  output logic        pcOrRegisterSelectionLine,
  output logic        addressFromRegOrDecoderSelectionLine,
  output logic        writeBackToRegRamOrALUSelectionLine,
  output logic        pcOrAluOutputRamReadSelectionLine,
  output logic [3:0]  registerWriteAddress,
  output logic        halted,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_LOAD_WB = 3'd4,
    S_HALTED  = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE  = 4'd0,
    C_IMM_ZX = 4'd1,
    C_IMM_SX = 4'd2,
    C_LOAD   = 4'd3,
    C_STOR   = 4'd4,
    C_JUMP   = 4'd5,
    C_HALT   = 4'd6,
    C_BR     = 4'd7,
    C_NOP    = 4'd8
  } class_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] w_pc_next;
  logic [15:0] w_pc_inc;
  logic        w_ir_load;
  class_t      w_class;

  assign w_pc_inc = r_pc + 16'd1;

  always_comb begin
    w_class = C_NOP;
    case (r_ir[15:12])
      4'b0000:                         w_class = C_RTYPE;
      4'b0001, 4'b0010, 4'b0011:       w_class = C_IMM_ZX;
      4'b0101, 4'b1001, 4'b1011,
      4'b1101, 4'b1111:                w_class = C_IMM_SX;
      4'b1100:                         w_class = C_BR;
      4'b0100: begin
        if      (r_ir[7:4] == 4'b0000)    w_class = C_LOAD;
        else if (r_ir[7:4] == 4'b0100)    w_class = C_STOR;
        else if (r_ir[7:4] == 4'b1100)    w_class = C_JUMP;
        else if (r_ir[7:4] == HALT_OPEXT) w_class = C_HALT;
        else                              w_class = C_NOP;
      end
      default:                         w_class = C_NOP;
    endcase
  end

  always_comb begin
    w_state_next                         = r_state;
    w_pc_next                            = r_pc;
    w_ir_load                            = 1'b0;
    blockRamReadEnable                   = 1'b0;
    blockRamWriteEnable                  = 1'b0;
    registerFileWriteEnable              = 1'b0;
    integerTypeSelectionLine             = 2'd0;
    reg2OrImmediateSelectionLine         = 1'b0;
    pcOrRegisterSelectionLine            = 1'b0;
    addressFromRegOrDecoderSelectionLine = 1'b0;
    writeBackToRegRamOrALUSelectionLine  = 1'b0;
    pcOrAluOutputRamReadSelectionLine    = 1'b0;
    halted                               = 1'b0;
    busy                                 = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bootLoad) begin
          w_pc_next = bootPc;
        end else if (run) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        busy                              = 1'b1;
        blockRamReadEnable                = 1'b1;
        pcOrAluOutputRamReadSelectionLine = 1'b1;
        w_state_next                      = S_DECODE;
      end
      S_DECODE: begin
        busy         = 1'b1;
        w_ir_load    = 1'b1;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        busy         = 1'b1;
        w_state_next = run ? S_FETCH : S_IDLE;
        w_pc_next    = w_pc_inc;
        case (w_class)
          C_RTYPE, C_IMM_ZX, C_IMM_SX: begin
            registerFileWriteEnable             = 1'b1;
            pcOrRegisterSelectionLine           = 1'b1;
            writeBackToRegRamOrALUSelectionLine = 1'b1;
            if (w_class != C_RTYPE) begin
              reg2OrImmediateSelectionLine = 1'b1;
              integerTypeSelectionLine     = (w_class == C_IMM_ZX) ? 2'd2 : 2'd1;
            end
          end
          C_LOAD: begin
            // PC advances in LOAD_WB so the write-back is tied to this instruction
            blockRamReadEnable           = 1'b1;
            pcOrRegisterSelectionLine    = 1'b1;
            reg2OrImmediateSelectionLine = 1'b1;
            integerTypeSelectionLine     = 2'd3;
            w_pc_next                    = r_pc;
            w_state_next                 = S_LOAD_WB;
          end
          C_STOR: begin
            blockRamWriteEnable          = 1'b1;
            pcOrRegisterSelectionLine    = 1'b1;
            reg2OrImmediateSelectionLine = 1'b1;
            integerTypeSelectionLine     = 2'd3;
          end
          C_BR: begin
            reg2OrImmediateSelectionLine = 1'b1;
            integerTypeSelectionLine     = 2'd1;
            w_pc_next                    = aluOutput;
          end
          C_JUMP: begin
            pcOrRegisterSelectionLine    = 1'b1;
            reg2OrImmediateSelectionLine = 1'b1;
            integerTypeSelectionLine     = 2'd3;
            w_pc_next                    = aluOutput;
          end
          C_HALT: begin
            w_pc_next    = r_pc;
            w_state_next = S_HALTED;
          end
          default: ;
        endcase
      end
      S_LOAD_WB: begin
        busy                    = 1'b1;
        registerFileWriteEnable = 1'b1;
        w_pc_next               = w_pc_inc;
        w_state_next            = run ? S_FETCH : S_IDLE;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (!run) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_ir_load) r_ir <= ramReadData;
    end
  end

  assign instruction          = r_ir;
  assign programCounter       = r_pc;
  assign registerWriteAddress = r_ir[11:8];

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_sequencer
// Description : Directed self-checking bench for instruction_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        bootLoad = 1'b0;
  logic [15:0] bootPc = 16'h0000;
  logic [15:0] ramReadData = 16'h0000;
  logic [15:0] aluOutput = 16'h0000;
  logic [15:0] instruction;
  logic [15:0] programCounter;
  logic        blockRamReadEnable, blockRamWriteEnable, registerFileWriteEnable;
  logic [1:0]  integerTypeSelectionLine;
  logic        reg2OrImmediateSelectionLine, pcOrRegisterSelectionLine;
  logic        addressFromRegOrDecoderSelectionLine, writeBackToRegRamOrALUSelectionLine;
  logic        pcOrAluOutputRamReadSelectionLine;
  logic [3:0]  registerWriteAddress;
  logic        halted, busy;

  logic [15:0] mem [0:65535];
  int          n_checks = 0;
  int          n_fail = 0;

  // {rdEn, wrEn, rfWe, intType[1:0], r2i, pcr, addrSel, wb, ramSel, halted, busy}
  localparam logic [11:0] CTL_IDLE   = 12'b0000_0000_0000;
  localparam logic [11:0] CTL_FETCH  = 12'b1000_0000_0101;
  localparam logic [11:0] CTL_DECODE = 12'b0000_0000_0001;
  localparam logic [11:0] CTL_RTYPE  = 12'b0010_0010_1001;
  localparam logic [11:0] CTL_IMM_SX = 12'b0010_1110_1001;
  localparam logic [11:0] CTL_IMM_ZX = 12'b0011_0110_1001;
  localparam logic [11:0] CTL_LOAD   = 12'b1001_1110_0001;
  localparam logic [11:0] CTL_LOADWB = 12'b0010_0000_0001;
  localparam logic [11:0] CTL_STOR   = 12'b0101_1110_0001;
  localparam logic [11:0] CTL_JUMP   = 12'b0001_1110_0001;
  localparam logic [11:0] CTL_BR     = 12'b0000_1100_0001;
  localparam logic [11:0] CTL_NOP    = 12'b0000_0000_0001;
  localparam logic [11:0] CTL_HALTED = 12'b0000_0000_0010;

  logic [11:0] ctl;
  assign ctl = {blockRamReadEnable, blockRamWriteEnable, registerFileWriteEnable,
                integerTypeSelectionLine, reg2OrImmediateSelectionLine,
                pcOrRegisterSelectionLine, addressFromRegOrDecoderSelectionLine,
                writeBackToRegRamOrALUSelectionLine, pcOrAluOutputRamReadSelectionLine,
                halted, busy};

  instruction_sequencer #(.RESET_PC(16'h0000), .HALT_OPEXT(4'hF)) dut (
    .clock                                (clock),
    .reset                                (reset),
    .run                                  (run),
    .bootLoad                             (bootLoad),
    .bootPc                               (bootPc),
    .ramReadData                          (ramReadData),
    .aluOutput                            (aluOutput),
    .instruction                          (instruction),
    .programCounter                       (programCounter),
    .blockRamReadEnable                   (blockRamReadEnable),
    .blockRamWriteEnable                  (blockRamWriteEnable),
    .registerFileWriteEnable              (registerFileWriteEnable),
    .integerTypeSelectionLine             (integerTypeSelectionLine),
    .reg2OrImmediateSelectionLine         (reg2OrImmediateSelectionLine),
    .pcOrRegisterSelectionLine            (pcOrRegisterSelectionLine),
    .addressFromRegOrDecoderSelectionLine (addressFromRegOrDecoderSelectionLine),
    .writeBackToRegRamOrALUSelectionLine  (writeBackToRegRamOrALUSelectionLine),
    .pcOrAluOutputRamReadSelectionLine    (pcOrAluOutputRamReadSelectionLine),
    .registerWriteAddress                 (registerWriteAddress),
    .halted                               (halted),
    .busy                                 (busy)
  );

  always #5 clock = ~clock;

  // Synchronous-read block RAM with one cycle of latency
  always @(posedge clock) begin
    if (blockRamReadEnable)
      ramReadData <= pcOrAluOutputRamReadSelectionLine ? mem[programCounter] : mem[aluOutput];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From IDLE: boot to pc, start one instruction; returns in FETCH with run low
  task automatic start_single(input logic [15:0] pc);
    bootLoad = 1'b1;
    bootPc   = pc;
    tick();
    bootLoad = 1'b0;
    run      = 1'b1;
    tick();
    run      = 1'b0;
  endtask

  task automatic test_reset();
    run = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL rst_ctl: got %b want %b", ctl, CTL_IDLE); end
    n_checks++; if (programCounter !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", programCounter); end
    n_checks++; if (instruction !== 16'h0000) begin n_fail++; $display("FAIL rst_ir: got %h want 0000", instruction); end
    reset = 1'b1;
    tick();
    n_checks++; if (ctl !== CTL_FETCH) begin n_fail++; $display("FAIL r1_fetch: got %b want %b", ctl, CTL_FETCH); end
    tick();
    n_checks++; if (ctl !== CTL_DECODE) begin n_fail++; $display("FAIL r1_decode: got %b want %b", ctl, CTL_DECODE); end
    tick();
    n_checks++; if (ctl !== CTL_RTYPE) begin n_fail++; $display("FAIL r1_exec: got %b want %b", ctl, CTL_RTYPE); end
    n_checks++; if (instruction !== 16'h0123) begin n_fail++; $display("FAIL r1_ir: got %h want 0123", instruction); end
    n_checks++; if (registerWriteAddress !== 4'd1) begin n_fail++; $display("FAIL r1_waddr: got %0d want 1", registerWriteAddress); end
  endtask

  task automatic test_back_to_back();
    tick();
    n_checks++; if (ctl !== CTL_FETCH) begin n_fail++; $display("FAIL b2b_fetch: got %b want %b", ctl, CTL_FETCH); end
    n_checks++; if (programCounter !== 16'h0001) begin n_fail++; $display("FAIL b2b_pc1: got %h want 0001", programCounter); end
    tick();
    tick();
    n_checks++; if (ctl !== CTL_IMM_ZX) begin n_fail++; $display("FAIL b2b_exec: got %b want %b", ctl, CTL_IMM_ZX); end
    run = 1'b0;
    tick();
    n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL b2b_idle: got %b want %b", ctl, CTL_IDLE); end
    n_checks++; if (programCounter !== 16'h0002) begin n_fail++; $display("FAIL b2b_pc2: got %h want 0002", programCounter); end
  endtask

  task automatic test_immediate();
    start_single(16'h0005);
    tick();
    tick();
    n_checks++; if (ctl !== CTL_IMM_SX) begin n_fail++; $display("FAIL imm_sx: got %b want %b", ctl, CTL_IMM_SX); end
    tick();
    n_checks++; if (programCounter !== 16'h0006) begin n_fail++; $display("FAIL imm_sx_pc: got %h want 0006", programCounter); end
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    n_checks++; if (ctl !== CTL_IMM_ZX) begin n_fail++; $display("FAIL imm_zx: got %b want %b", ctl, CTL_IMM_ZX); end
    tick();
    n_checks++; if (programCounter !== 16'h0007) begin n_fail++; $display("FAIL imm_zx_pc: got %h want 0007", programCounter); end
  endtask

  task automatic test_load();
    aluOutput = 16'h0020;
    start_single(16'h0007);
    n_checks++; if (ctl !== CTL_FETCH) begin n_fail++; $display("FAIL ld_fetch: got %b want %b", ctl, CTL_FETCH); end
    tick();
    tick();
    n_checks++; if (ctl !== CTL_LOAD) begin n_fail++; $display("FAIL ld_exec: got %b want %b", ctl, CTL_LOAD); end
    tick();
    n_checks++; if (ctl !== CTL_LOADWB) begin n_fail++; $display("FAIL ld_wb: got %b want %b", ctl, CTL_LOADWB); end
    n_checks++; if (programCounter !== 16'h0007) begin n_fail++; $display("FAIL ld_wb_pc: got %h want 0007", programCounter); end
    n_checks++; if (registerWriteAddress !== 4'd3) begin n_fail++; $display("FAIL ld_waddr: got %0d want 3", registerWriteAddress); end
    n_checks++; if (ramReadData !== 16'hBEEF) begin n_fail++; $display("FAIL ld_data: got %h want beef", ramReadData); end
    tick();
    n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL ld_idle: got %b want %b", ctl, CTL_IDLE); end
    n_checks++; if (programCounter !== 16'h0008) begin n_fail++; $display("FAIL ld_pc: got %h want 0008", programCounter); end
  endtask

  task automatic test_branch_wrap();
    aluOutput = 16'h0040;
    start_single(16'h0008);
    tick();
    tick();
    n_checks++; if (ctl !== CTL_BR) begin n_fail++; $display("FAIL br_exec: got %b want %b", ctl, CTL_BR); end
    tick();
    n_checks++; if (programCounter !== 16'h0040) begin n_fail++; $display("FAIL br_pc: got %h want 0040", programCounter); end
    start_single(16'hFFFF);
    tick();
    tick();
    n_checks++; if (ctl !== CTL_NOP) begin n_fail++; $display("FAIL nop_exec: got %b want %b", ctl, CTL_NOP); end
    tick();
    n_checks++; if (programCounter !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h want 0000", programCounter); end
  endtask

  task automatic test_store_jump();
    start_single(16'h0030);
    tick();
    tick();
    n_checks++; if (ctl !== CTL_STOR) begin n_fail++; $display("FAIL st_exec: got %b want %b", ctl, CTL_STOR); end
    tick();
    n_checks++; if (programCounter !== 16'h0031) begin n_fail++; $display("FAIL st_pc: got %h want 0031", programCounter); end
    aluOutput = 16'h1234;
    start_single(16'h0031);
    tick();
    tick();
    n_checks++; if (ctl !== CTL_JUMP) begin n_fail++; $display("FAIL jmp_exec: got %b want %b", ctl, CTL_JUMP); end
    tick();
    n_checks++; if (programCounter !== 16'h1234) begin n_fail++; $display("FAIL jmp_pc: got %h want 1234", programCounter); end
  endtask

  task automatic test_halt();
    bootLoad = 1'b1;
    bootPc   = 16'h0010;
    tick();
    bootLoad = 1'b0;
    run      = 1'b1;
    tick();
    tick();
    tick();
    n_checks++; if (ctl !== CTL_NOP) begin n_fail++; $display("FAIL hlt_exec: got %b want %b", ctl, CTL_NOP); end
    tick();
    n_checks++; if (ctl !== CTL_HALTED) begin n_fail++; $display("FAIL hlt_state: got %b want %b", ctl, CTL_HALTED); end
    bootLoad = 1'b1;
    bootPc   = 16'h0200;
    tick();
    bootLoad = 1'b0;
    tick();
    n_checks++; if (ctl !== CTL_HALTED) begin n_fail++; $display("FAIL hlt_hold: got %b want %b", ctl, CTL_HALTED); end
    n_checks++; if (programCounter !== 16'h0010) begin n_fail++; $display("FAIL hlt_pc: got %h want 0010", programCounter); end
    run = 1'b0;
    tick();
    n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL hlt_exit: got %b want %b", ctl, CTL_IDLE); end
    bootLoad = 1'b1;
    bootPc   = 16'h0100;
    run      = 1'b1;
    tick();
    bootLoad = 1'b0;
    run      = 1'b0;
    n_checks++; if (programCounter !== 16'h0100) begin n_fail++; $display("FAIL boot_pc: got %h want 0100", programCounter); end
    n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL boot_idle: got %b want %b", ctl, CTL_IDLE); end
  endtask

  task automatic test_reset_mid();
    aluOutput = 16'h0020;
    start_single(16'h0007);
    tick();
    tick();
    tick();
    n_checks++; if (ctl !== CTL_LOADWB) begin n_fail++; $display("FAIL rm_wb: got %b want %b", ctl, CTL_LOADWB); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL rm_ctl: got %b want %b", ctl, CTL_IDLE); end
    n_checks++; if (programCounter !== 16'h0000) begin n_fail++; $display("FAIL rm_pc: got %h want 0000", programCounter); end
    n_checks++; if (instruction !== 16'h0000) begin n_fail++; $display("FAIL rm_ir: got %h want 0000", instruction); end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (ctl !== CTL_IDLE) begin n_fail++; $display("FAIL rm_stay: got %b want %b", ctl, CTL_IDLE); end
    run = 1'b1;
    tick();
    n_checks++; if (ctl !== CTL_FETCH) begin n_fail++; $display("FAIL rm_run: got %b want %b", ctl, CTL_FETCH); end
    run = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h6000;
    mem[16'h0000] = 16'h0123;
    mem[16'h0001] = 16'h1207;
    mem[16'h0005] = 16'h5207;
    mem[16'h0006] = 16'h1207;
    mem[16'h0007] = 16'h4302;
    mem[16'h0008] = 16'hC000;
    mem[16'h0010] = 16'h40F0;
    mem[16'h0020] = 16'hBEEF;
    mem[16'h0030] = 16'h4640;
    mem[16'h0031] = 16'h40C0;
    test_reset();
    test_back_to_back();
    test_immediate();
    test_load();
    test_branch_wrap();
    test_store_jump();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
